// File: rtl/phy_tx_pkg.sv
// Shared definitions for the PHY transmit path: scheduler state encoding,
// COM symbol value and default training length.
package phy_tx_pkg;

  localparam int         TRAIN_LEN_DEF = 4;
  localparam logic [7:0] COM_SYM       = 8'hBC;

  typedef enum logic [1:0] {
    S_TRAIN = 2'd0,
    S_IDLE  = 2'd1,
    S_BUSY  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, and on contention
// the lane named by prio wins. Output is one-hot, or zero when nobody asks.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = prio ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/tx_lane_scheduler.sv
// Two-lane packet scheduler: trains after reset, then grants whole packets
// to one lane at a time and registers the accepted bytes toward the serializer.
//   state   | meaning
//   S_TRAIN | link training, counts TRAIN_LEN cycles, no traffic
//   S_IDLE  | link up, no owner; arbitrates between requesting lanes
//   S_BUSY  | owner lane streams bytes until its last byte is taken
module tx_lane_scheduler
  import phy_tx_pkg::*;
#(
  parameter int TRAIN_LEN = TRAIN_LEN_DEF,
  parameter int DATA_W    = 8
) (
  input  logic              dclk,
  input  logic              default_values,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              last0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  input  logic              last1,
  output logic              ack1,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              link_up,
  output logic [1:0]        gnt
);

  localparam int CNT_W = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;

  tx_state_e         r_state;
  tx_state_e         w_next_state;
  logic [CNT_W-1:0]  r_train_cnt;
  logic              r_prio;
  logic [1:0]        r_gnt;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        w_pick;
  logic [1:0]        w_ack;
  logic              w_end_pkt;

  rr_pick2 u_pick (
    .req  ({req1, req0}),
    .prio (r_prio),
    .pick (w_pick)
  );

  always_comb begin
    w_next_state = r_state;
    w_ack        = 2'b00;
    case (r_state)
      S_TRAIN: if (r_train_cnt == CNT_W'(TRAIN_LEN - 1)) w_next_state = S_IDLE;
      S_IDLE:  if (|w_pick) w_next_state = S_BUSY;
      S_BUSY: begin
        w_ack = r_gnt & {req1, req0};
        if (|(w_ack & {last1, last0})) w_next_state = S_IDLE;
      end
      default: w_next_state = S_TRAIN;
    endcase
    if (default_values) w_ack = 2'b00;
  end

  assign w_end_pkt = |(w_ack & {last1, last0});

  always_ff @(posedge dclk) begin
    if (default_values) begin
      r_state     <= S_TRAIN;
      r_train_cnt <= '0;
      r_prio      <= 1'b0;
      r_gnt       <= 2'b00;
      r_valid     <= 1'b0;
      r_data      <= '0;
    end else begin
      r_state <= w_next_state;
      r_valid <= |w_ack;
      if (r_state == S_TRAIN) r_train_cnt <= r_train_cnt + 1'b1;
      if (r_state == S_IDLE) r_gnt <= w_pick;
      // The lane that just finished yields priority to the other one.
      if (r_state == S_BUSY && w_end_pkt) begin
        r_gnt  <= 2'b00;
        r_prio <= r_gnt[0];
      end
      if (|w_ack) r_data <= r_gnt[1] ? data1 : data0;
    end
  end

  assign ack0      = w_ack[0];
  assign ack1      = w_ack[1];
  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign link_up   = (r_state != S_TRAIN);
  assign gnt       = r_gnt;

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Scoreboard bench for tx_lane_scheduler: a lane-level reference model queues
// per-cycle expectations and payload bytes; a monitor compares at negedge.
module tb_tx_lane_scheduler;
  import phy_tx_pkg::*;

  localparam int DW = 8;
  localparam int TL = 4;

  logic          dclk = 1'b0;
  logic          default_values;
  logic          req0, last0, ack0, req1, last1, ack1;
  logic [DW-1:0] data0, data1, data_out;
  logic          valid_out, link_up;
  logic [1:0]    gnt;

  always #5 dclk = ~dclk;

  tx_lane_scheduler #(.TRAIN_LEN(TL), .DATA_W(DW)) dut (
    .dclk           (dclk),
    .default_values (default_values),
    .req0           (req0),
    .data0          (data0),
    .last0          (last0),
    .ack0           (ack0),
    .req1           (req1),
    .data1          (data1),
    .last1          (last1),
    .ack1           (ack1),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .link_up        (link_up),
    .gnt            (gnt)
  );

  typedef struct packed {
    logic       a0;
    logic       a1;
    logic [1:0] g;
    logic       lu;
    logic       v;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] byte_q[$];
  logic [8:0] lq0[$];
  logic [8:0] lq1[$];
  int         stall0 = 0, stall1 = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lane-level view of the link
  bit         m_known = 1'b0;
  int         m_train_left = 0;
  int         m_owner = -1;
  int         m_prio = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst);
    bit r0, r1, l0, l1, a0, a1;
    logic [7:0] d0, d1;
    exp_t e;
    r0 = (lq0.size() > 0) && (stall0 == 0);
    r1 = (lq1.size() > 0) && (stall1 == 0);
    d0 = r0 ? lq0[0][7:0] : 8'($urandom);
    l0 = r0 ? lq0[0][8]   : 1'($urandom);
    d1 = r1 ? lq1[0][7:0] : 8'($urandom);
    l1 = r1 ? lq1[0][8]   : 1'($urandom);
    default_values = rst;
    req0 = r0; data0 = d0; last0 = l0;
    req1 = r1; data1 = d1; last1 = l1;
    a0 = 1'b0;
    a1 = 1'b0;
    if (m_known) begin
      if (!rst && m_train_left == 0 && m_owner >= 0) begin
        a0 = (m_owner == 0) && r0;
        a1 = (m_owner == 1) && r1;
      end
      e.a0 = a0;
      e.a1 = a1;
      e.g  = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
      e.lu = (m_train_left == 0);
      e.v  = m_valid;
      e.d  = m_data;
      exp_q.push_back(e);
    end
    if (a0 || a1) byte_q.push_back(a0 ? d0 : d1);
    if (rst) begin
      m_known = 1'b1; m_train_left = TL; m_owner = -1; m_prio = 0;
      m_valid = 1'b0; m_data = 8'h00;
    end else if (m_known) begin
      m_valid = a0 || a1;
      if (m_valid) m_data = a0 ? d0 : d1;
      if (m_train_left > 0) m_train_left--;
      else if (m_owner < 0) begin
        if (r0 && r1) m_owner = m_prio;
        else if (r0) m_owner = 0;
        else if (r1) m_owner = 1;
      end else if ((a0 && l0) || (a1 && l1)) begin
        m_prio  = 1 - m_owner;
        m_owner = -1;
      end
    end
    if (a0) void'(lq0.pop_front());
    if (a1) void'(lq1.pop_front());
    if (stall0 > 0) stall0--;
    if (stall1 > 0) stall1--;
    if (rst) begin
      lq0.delete();
      lq1.delete();
    end
    @(posedge dclk);
    #1;
  endtask

  task automatic push_pkt(input int lane, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      if (lane == 0) lq0.push_back({(i == len - 1), 8'(base + i)});
      else           lq1.push_back({(i == len - 1), 8'(base + i)});
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((lq0.size() > 0 || lq1.size() > 0 || m_owner >= 0 || m_train_left > 0) && n < budget) begin
      step(1'b0);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d cycles required < %0d", n, budget);
    end
    step(1'b0);
    step(1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [7:0] b;
    forever begin
      @(negedge dclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ack0", 32'(ack0), 32'(e.a0));
        chk("ack1", 32'(ack1), 32'(e.a1));
        chk("gnt", 32'(gnt), 32'(e.g));
        chk("link_up", 32'(link_up), 32'(e.lu));
        chk("valid_out", 32'(valid_out), 32'(e.v));
        chk("data_out", 32'(data_out), 32'(e.d));
        if (valid_out === 1'b1) begin
          if (byte_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL payload_unexpected: got byte %0h required none", data_out);
          end else begin
            b = byte_q.pop_front();
            chk("payload", 32'(data_out), 32'(b));
          end
        end
      end
    end
  end

  initial begin
    default_values = 1'b1;
    req0 = 1'b0; data0 = '0; last0 = 1'b0;
    req1 = 1'b0; data1 = '0; last1 = 1'b0;

    // Reset, then training with no requests
    do_reset(2);
    for (int i = 0; i < 8; i++) step(1'b0);

    // Lane 0 three-byte packet, lane 1 idle
    lq0.push_back({1'b0, 8'hA1});
    lq0.push_back({1'b0, 8'hA2});
    lq0.push_back({1'b1, 8'hA3});
    drain(50);

    // Contention right after reset, then contention again
    do_reset(2);
    drain(20);
    push_pkt(0, 2, 8'h10);
    push_pkt(1, 3, 8'h20);
    drain(50);
    push_pkt(0, 2, 8'h30);
    push_pkt(1, 2, 8'h40);
    drain(50);

    // Lane 1 owner stalls two cycles while lane 0 waits
    push_pkt(1, 4, 8'h60);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    push_pkt(0, 2, 8'h70);
    stall1 = 2;
    drain(50);

    // Single-byte packet
    lq0.push_back({1'b1, 8'h55});
    drain(20);

    // Reset during the second byte of a four-byte packet, then retrain
    push_pkt(0, 4, 8'h80);
    for (int i = 0; i < 20 && lq0.size() > 3; i++) step(1'b0);
    step(1'b1);
    push_pkt(0, 2, 8'h90);
    drain(50);

    // Randomized traffic with stalls and occasional reset
    for (int c = 0; c < 600; c++) begin
      if (lq0.size() == 0 && $urandom_range(0, 7) == 0)
        push_pkt(0, $urandom_range(1, 4), 8'($urandom));
      if (lq1.size() == 0 && $urandom_range(0, 7) == 0)
        push_pkt(1, $urandom_range(1, 4), 8'($urandom));
      if ($urandom_range(0, 9) == 0) stall0 = $urandom_range(1, 2);
      if ($urandom_range(0, 9) == 0) stall1 = $urandom_range(1, 2);
      step($urandom_range(0, 199) == 0);
    end
    drain(200);
    step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
